bitrev_swap_scheduler: RTL and testbench

Sequences the registered bit-reversal unit across a full index sweep and turns its results into an in-place permutation schedule. After `start`, it walks `idx = 0 … N-1` with `N = 2^W` and `W = RADIX_K1*l`, drives the external bit-reversal unit, and pairs each index with its 1-cycle-late reversed value. It emits one swap request `(a, b)` for every pair with `a < rev(a)`, through a valid/ready port. It sits between the NWC stage controller and the coefficient-memory port that performs the reorder before and after NTT passes.

---
 rtl/bitrev_swap_scheduler_if.sv | 34 +++
 rtl/bitrev_swap_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_bitrev_swap_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitrev_swap_scheduler_if.sv
// Bundle of the control, bit-reversal-unit and swap-request signals of
// bitrev_swap_scheduler. The scheduler connects through the slave modport;
// the surrounding logic (stage controller, reversal unit, memory port)
// connects through the master modport.
interface bitrev_swap_scheduler_if #(
  parameter int D_WIDTH = 16
);
  logic               start;
  logic [D_WIDTH-1:0] l_cfg;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [D_WIDTH-1:0] bitrev_idx;
  logic               bitrev_en;
  logic [D_WIDTH-1:0] bitrev_l;
  logic [D_WIDTH-1:0] bitrev_out;
  logic               swap_valid;
  logic               swap_ready;
  logic [D_WIDTH-1:0] swap_a;
  logic [D_WIDTH-1:0] swap_b;
  logic [D_WIDTH-1:0] swap_cnt;

  modport slave (
    input  start, l_cfg, bitrev_out, swap_ready,
    output busy, done, cfg_err, bitrev_idx, bitrev_en, bitrev_l,
           swap_valid, swap_a, swap_b, swap_cnt
  );

  modport master (
    output start, l_cfg, bitrev_out, swap_ready,
    input  busy, done, cfg_err, bitrev_idx, bitrev_en, bitrev_l,
           swap_valid, swap_a, swap_b, swap_cnt
  );
endinterface

// File: rtl/bitrev_swap_scheduler.sv
// Walks idx = 0 .. 2^W-1 through an external registered bit-reversal unit
// and turns each (idx, rev(idx)) pair with idx < rev into one swap request.
// Results land in a 2-entry shift FIFO whose head drives the swap port.
// Issue is throttled so that the FIFO plus everything still in the
// reversal pipeline can never exceed two entries.
module bitrev_swap_scheduler #(
  parameter int D_WIDTH  = 16,
  parameter int RADIX_K1 = 2
) (
  input logic                    clk,
  input logic                    rst,
  bitrev_swap_scheduler_if.slave bus
);

  localparam int               LW     = 2 * D_WIDTH;
  localparam logic [D_WIDTH-1:0] ZERO_D = {D_WIDTH{1'b0}};
  localparam logic [D_WIDTH-1:0] ONE_D  = {{(D_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mask of the low w bits; built bitwise so w == D_WIDTH needs no overflow.
  function automatic logic [D_WIDTH-1:0] low_mask(input logic [LW-1:0] w);
    logic [D_WIDTH-1:0] m;
    m = ZERO_D;
    for (int i = 0; i < D_WIDTH; i++) begin
      m[i] = (LW'(i) < w);
    end
    return m;
  endfunction

  state_t             state_r, state_next_s;
  logic [D_WIDTH-1:0] l_r;
  logic [D_WIDTH-1:0] mask_r;
  logic [D_WIDTH-1:0] idx_ctr_r;
  logic [D_WIDTH-1:0] bitrev_idx_r;
  logic               bitrev_en_r;
  logic [D_WIDTH-1:0] idx_d_r;
  logic               cmp_v_r;
  logic               busy_r, done_r, cfg_err_r;
  logic [D_WIDTH-1:0] swap_cnt_r;
  logic               v0_r, v1_r;
  logic [D_WIDTH-1:0] a0_r, b0_r, a1_r, b1_r;

  logic [LW-1:0]      w_req_s;
  logic               cfg_ok_s;
  logic               start_ok_s, start_bad_s;
  logic               issue_s, push_s, pop_s;
  logic [D_WIDTH-1:0] rev_s;
  logic [1:0]         fifo_next_s;
  logic [2:0]         lookahead_s;

  // Config legality, compare stage, FIFO occupancy and next-state logic.
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    start_bad_s  = 1'b0;
    issue_s      = 1'b0;
    w_req_s      = LW'(bus.l_cfg) * LW'(RADIX_K1);
    cfg_ok_s     = (bus.l_cfg != ZERO_D) && (w_req_s <= LW'(D_WIDTH));
    rev_s        = bus.bitrev_out & mask_r;
    push_s       = cmp_v_r && ((idx_d_r & mask_r) < rev_s);
    pop_s        = v0_r && bus.swap_ready;
    fifo_next_s  = {1'b0, v0_r} + {1'b0, v1_r} + {1'b0, push_s} - {1'b0, pop_s};
    // The index in the reversal unit still needs a FIFO slot in the worst case.
    lookahead_s  = {1'b0, fifo_next_s} + {2'b00, bitrev_en_r};
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_ok_s) begin
            start_ok_s   = 1'b1;
            state_next_s = ST_RUN;
          end else begin
            start_bad_s  = 1'b1;
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (lookahead_s < 3'd2) begin
          issue_s = 1'b1;
          if (idx_ctr_r == mask_r) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!bitrev_en_r && (fifo_next_s == 2'd0)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered status outputs and sweep configuration latched on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      l_r       <= ZERO_D;
      mask_r    <= ZERO_D;
    end else begin
      busy_r <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
      done_r <= (state_next_s == ST_DONE);
      if (start_ok_s) begin
        cfg_err_r <= 1'b0;
        l_r       <= bus.l_cfg;
        mask_r    <= low_mask(w_req_s);
      end else if (start_bad_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  // Index counter, registered issue to the reversal unit and compare stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_ctr_r    <= ZERO_D;
      bitrev_idx_r <= ZERO_D;
      bitrev_en_r  <= 1'b0;
      idx_d_r      <= ZERO_D;
      cmp_v_r      <= 1'b0;
    end else begin
      bitrev_en_r <= issue_s;
      cmp_v_r     <= bitrev_en_r;
      if (start_ok_s) begin
        idx_ctr_r <= ZERO_D;
      end else if (issue_s) begin
        idx_ctr_r <= idx_ctr_r + ONE_D;
      end
      if (issue_s) begin
        bitrev_idx_r <= idx_ctr_r;
      end
      if (bitrev_en_r) begin
        idx_d_r <= bitrev_idx_r;
      end
    end
  end

  // Two-entry shift FIFO: slot 0 is always the head seen on the swap port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r <= 1'b0;
      v1_r <= 1'b0;
      a0_r <= ZERO_D;
      b0_r <= ZERO_D;
      a1_r <= ZERO_D;
      b1_r <= ZERO_D;
    end else if (!v0_r) begin
      if (push_s) begin
        v0_r <= 1'b1;
        a0_r <= idx_d_r;
        b0_r <= rev_s;
      end
    end else if (!v1_r) begin
      case ({push_s, pop_s})
        2'b10: begin
          v1_r <= 1'b1;
          a1_r <= idx_d_r;
          b1_r <= rev_s;
        end
        2'b01: begin
          v0_r <= 1'b0;
        end
        2'b11: begin
          a0_r <= idx_d_r;
          b0_r <= rev_s;
        end
        default: begin
          v0_r <= v0_r;
        end
      endcase
    end else if (pop_s) begin
      a0_r <= a1_r;
      b0_r <= b1_r;
      if (push_s) begin
        a1_r <= idx_d_r;
        b1_r <= rev_s;
      end else begin
        v1_r <= 1'b0;
      end
    end
  end

  // Count of swaps accepted downstream during the current sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_cnt_r <= ZERO_D;
    end else if (start_ok_s) begin
      swap_cnt_r <= ZERO_D;
    end else if (pop_s) begin
      swap_cnt_r <= swap_cnt_r + ONE_D;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.cfg_err    = cfg_err_r;
  assign bus.bitrev_idx = bitrev_idx_r;
  assign bus.bitrev_en  = bitrev_en_r;
  assign bus.bitrev_l   = l_r;
  assign bus.swap_valid = v0_r;
  assign bus.swap_a     = a0_r;
  assign bus.swap_b     = b0_r;
  assign bus.swap_cnt   = swap_cnt_r;

endmodule

// File: tb/tb_bitrev_swap_scheduler.sv
// Randomized bench for bitrev_swap_scheduler. A behavioural bit-reversal
// unit answers the scheduler; the expected swap list of each sweep is built
// up front from the pairing rule (a < rev(a)) and consumed as swaps pop.
module tb_bitrev_swap_scheduler;
  localparam int DW = 16;
  localparam int RK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  always #5 clk = ~clk;

  bitrev_swap_scheduler_if #(.D_WIDTH(DW)) bus ();

  bitrev_swap_scheduler #(.D_WIDTH(DW), .RADIX_K1(RK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reverse the low w bits of v using plain arithmetic.
  function automatic int rev_bits(input int v, input int w);
    int r;
    int t;
    r = 0;
    t = v;
    for (int i = 0; i < w; i++) begin
      r = r * 2 + t % 2;
      t = t / 2;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Registered bit-reversal unit driven by the scheduler.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bitrev_out <= '0;
    end else if (bus.bitrev_en) begin
      bus.bitrev_out <= DW'(rev_bits(int'(bus.bitrev_idx), int'(bus.bitrev_l) * RK));
    end
  end

  task automatic check_all_zero(input string ctx);
    check_val({ctx, "_busy"},       bus.busy,       0);
    check_val({ctx, "_done"},       bus.done,       0);
    check_val({ctx, "_cfg_err"},    bus.cfg_err,    0);
    check_val({ctx, "_bitrev_en"},  bus.bitrev_en,  0);
    check_val({ctx, "_swap_valid"}, bus.swap_valid, 0);
    check_val({ctx, "_bitrev_idx"}, bus.bitrev_idx, 0);
    check_val({ctx, "_bitrev_l"},   bus.bitrev_l,   0);
    check_val({ctx, "_swap_a"},     bus.swap_a,     0);
    check_val({ctx, "_swap_b"},     bus.swap_b,     0);
    check_val({ctx, "_swap_cnt"},   bus.swap_cnt,   0);
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready low for cycles 6..25.
  task automatic run_sweep(input int l, input int mode, input bit extra_starts,
                           input int abort_after, output bit aborted);
    int w, n, exp_swaps, budget, exp_idx, pops, done_cyc;
    int last_pop_cyc, last_issue_cyc, first_issue_cyc;
    int outstanding, max_out, busy_low, stall_issues, r, cmp_end;
    bit finished, held;
    int qa[$];
    int qb[$];
    logic [DW-1:0] held_a, held_b;
    w = l * RK;
    n = 1 << w;
    exp_idx = 0; pops = 0; done_cyc = -1;
    last_pop_cyc = -1; last_issue_cyc = -1; first_issue_cyc = -1;
    outstanding = 0; max_out = 0; busy_low = 0; stall_issues = 0;
    finished = 1'b0; held = 1'b0; aborted = 1'b0;
    held_a = '0; held_b = '0;
    budget = n * 8 + 60;
    for (int a = 0; a < n; a++) begin
      r = rev_bits(a, w);
      if (a < r) begin
        qa.push_back(a);
        qb.push_back(r);
      end
    end
    exp_swaps = (n - (1 << ((w + 1) / 2))) / 2;

    @(posedge clk); #1;
    bus.l_cfg      = DW'(l);
    bus.start      = 1'b1;
    bus.swap_ready = (mode == 1) ? ($urandom_range(0, 9) < 6) : 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    for (int cyc = 0; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check_val("busy_after_start", bus.busy, 1);
        check_val("cfg_err_cleared", bus.cfg_err, 0);
      end
      if (held) begin
        check_val("stall_hold_a", bus.swap_a, held_a);
        check_val("stall_hold_b", bus.swap_b, held_b);
      end
      if (bus.bitrev_en) begin
        if (first_issue_cyc < 0) begin
          first_issue_cyc = cyc;
        end
        check_val("issue_idx", bus.bitrev_idx, exp_idx);
        if (exp_idx < rev_bits(exp_idx, w)) outstanding++;
        exp_idx++;
        last_issue_cyc = cyc;
        if (mode == 2 && cyc >= 14 && cyc < 26) stall_issues++;
      end
      if (outstanding > max_out) max_out = outstanding;
      held   = bus.swap_valid && !bus.swap_ready;
      held_a = bus.swap_a;
      held_b = bus.swap_b;
      if (bus.swap_valid && bus.swap_ready) begin
        if (qa.size() == 0) begin
          check_val("unexpected_swap", 1, 0);
        end else begin
          check_val("swap_a", bus.swap_a, qa.pop_front());
          check_val("swap_b", bus.swap_b, qb.pop_front());
        end
        pops++;
        outstanding--;
        last_pop_cyc = cyc;
        if (abort_after != 0 && pops == abort_after) begin
          aborted = 1'b1;
          break;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        finished = 1'b1;
        check_val("swap_cnt_at_done", bus.swap_cnt, exp_swaps);
        break;
      end
      if (!bus.busy) busy_low++;
      @(posedge clk); #1;
      case (mode)
        1:       bus.swap_ready = ($urandom_range(0, 9) < 6);
        2:       bus.swap_ready = !((cyc + 1) >= 6 && (cyc + 1) < 26);
        default: bus.swap_ready = 1'b1;
      endcase
      if (extra_starts) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.l_cfg = DW'($urandom_range(0, 9));
      end
    end
    bus.start = 1'b0;
    if (aborted) return;

    check_val("sweep_finished", finished, 1);
    check_val("first_issue_cycle", first_issue_cyc, 1);
    check_val("issued_count", exp_idx, n);
    check_val("pops_count", pops, exp_swaps);
    check_val("missing_swaps", qa.size(), 0);
    check_val("busy_during_sweep", busy_low, 0);
    check_val("over_two_buffered", max_out > 2, 0);
    check_val("bitrev_l_held", bus.bitrev_l, l);
    if (mode == 2) check_val("issue_while_stalled", stall_issues, 0);
    cmp_end = (last_issue_cyc + 1 > last_pop_cyc) ? last_issue_cyc + 1 : last_pop_cyc;
    check_val("done_cycle", done_cyc, cmp_end + 1);
    @(negedge clk);
    check_val("done_single_pulse", bus.done, 0);
    check_val("busy_after_done", bus.busy, 0);
  endtask

  task automatic err_start(input int l);
    int en_seen;
    en_seen = 0;
    @(posedge clk); #1;
    bus.l_cfg = DW'(l);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("err_cfg_err", bus.cfg_err, 1);
    check_val("err_done", bus.done, 1);
    check_val("err_busy", bus.busy, 0);
    if (bus.bitrev_en) en_seen++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.bitrev_en || bus.swap_valid) en_seen++;
    end
    check_val("err_done_dropped", bus.done, 0);
    check_val("err_cfg_err_held", bus.cfg_err, 1);
    check_val("err_no_activity", en_seen, 0);
  endtask

  initial begin
    bit ab;
    bus.start      = 1'b0;
    bus.l_cfg      = '0;
    bus.swap_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(1, 0, 1'b0, 0, ab);
    run_sweep(2, 1, 1'b0, 0, ab);
    run_sweep(2, 2, 1'b0, 0, ab);
    err_start(0);
    err_start(9);

    run_sweep(2, 0, 1'b0, 3, ab);
    check_val("abort_reached", ab, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("midsweep_reset");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(2, 0, 1'b0, 0, ab);

    run_sweep(2, 1, 1'b1, 0, ab);
    for (int k = 0; k < 4; k++) begin
      run_sweep(int'($urandom_range(1, 3)), 1, 1'b0, 0, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
